// File: rtl/beep_pkg.sv
// Shared types and parameter defaults for the buzzer driver.
package beep_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StTone,
      StGap
   } beep_state_t;

   localparam int unsigned DefHpW       = 16;
   localparam int unsigned DefDurW      = 8;
   localparam int unsigned DefTickCycles = 38000;
   localparam int unsigned DefGapTicks  = 20;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_CYCLES clocks.
module tick_prescaler
   import beep_pkg::*;
#(
   parameter int unsigned TICK_CYCLES = DefTickCycles
) (
   input  logic clk,
   input  logic n_reset,
   input  logic restart,
   output logic tick
);

   localparam int unsigned CntW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TICK_CYCLES - 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            wrap;

   always_comb begin
      wrap  = (cnt_q == CntLast);
      tick  = wrap & ~restart;
      cnt_d = cnt_q + 1'b1;
      if (restart || wrap) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/beep_driver.sv
// Buzzer driver: plays a square-wave tone for a number of ticks, then a fixed silent gap.
module beep_driver
   import beep_pkg::*;
#(
   parameter int unsigned HP_W        = DefHpW,
   parameter int unsigned DUR_W       = DefDurW,
   parameter int unsigned TICK_CYCLES = DefTickCycles,
   parameter int unsigned GAP_TICKS   = DefGapTicks
) (
   input  logic             clk,
   input  logic             n_reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [HP_W-1:0]  req_half_period,
   input  logic [DUR_W-1:0] req_duration,
   input  logic             abort,
   output logic             buzz_out,
   output logic             busy
);

   localparam int unsigned GapW = $clog2(GAP_TICKS + 1);
   localparam int unsigned TckW = (DUR_W > GapW) ? DUR_W : GapW;
   localparam logic [TckW-1:0] GapLast = (GAP_TICKS > 0) ? TckW'(GAP_TICKS - 1) : '0;

   beep_state_t      state_q, state_d;
   logic [HP_W-1:0]  hp_q, hp_d;
   logic [DUR_W-1:0] dur_q, dur_d;
   logic [HP_W-1:0]  hp_cnt_q, hp_cnt_d;
   logic [TckW-1:0]  tick_cnt_q, tick_cnt_d;
   logic             buzz_q, buzz_d;
   logic             restart;
   logic             tick;

   // Prescaler is held at zero while idle so every tone starts on a full tick.
   assign restart = (state_q == StIdle) | abort;

   tick_prescaler #(
      .TICK_CYCLES(TICK_CYCLES)
   ) u_prescaler (
      .clk    (clk),
      .n_reset(n_reset),
      .restart(restart),
      .tick   (tick)
   );

   assign req_ready = (state_q == StIdle) & ~abort;
   assign busy      = (state_q != StIdle);
   assign buzz_out  = buzz_q;

   always_comb begin
      state_d    = state_q;
      hp_d       = hp_q;
      dur_d      = dur_q;
      hp_cnt_d   = hp_cnt_q;
      tick_cnt_d = tick_cnt_q;
      buzz_d     = buzz_q;

      unique case (state_q)
         StIdle: begin
            if (req_valid && req_ready && (req_duration != '0)) begin
               state_d    = StTone;
               hp_d       = req_half_period;
               dur_d      = req_duration;
               hp_cnt_d   = '0;
               tick_cnt_d = '0;
               buzz_d     = 1'b0;
            end
         end
         StTone: begin
            if (hp_q != '0) begin
               if (hp_cnt_q == hp_q - 1'b1) begin
                  buzz_d   = ~buzz_q;
                  hp_cnt_d = '0;
               end else begin
                  hp_cnt_d = hp_cnt_q + 1'b1;
               end
            end
            // End of tone overrides a coincident toggle.
            if (tick) begin
               if (tick_cnt_q == TckW'(dur_q - 1'b1)) begin
                  buzz_d     = 1'b0;
                  hp_cnt_d   = '0;
                  tick_cnt_d = '0;
                  state_d    = (GAP_TICKS == 0) ? StIdle : StGap;
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
         end
         StGap: begin
            if (tick) begin
               if (tick_cnt_q == GapLast) begin
                  tick_cnt_d = '0;
                  state_d    = StIdle;
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (abort && (state_q != StIdle)) begin
         state_d    = StIdle;
         hp_cnt_d   = '0;
         tick_cnt_d = '0;
         buzz_d     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q    <= StIdle;
         hp_q       <= '0;
         dur_q      <= '0;
         hp_cnt_q   <= '0;
         tick_cnt_q <= '0;
         buzz_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         hp_q       <= hp_d;
         dur_q      <= dur_d;
         hp_cnt_q   <= hp_cnt_d;
         tick_cnt_q <= tick_cnt_d;
         buzz_q     <= buzz_d;
      end
   end

endmodule

// File: tb/tb_beep_driver.sv
// Scoreboard bench for beep_driver: occupancy-window reference model, per-cycle expectations.
module tb_beep_driver;

   localparam int HP_W  = 16;
   localparam int DUR_W = 8;
   localparam int TC    = 10;
   localparam int GT    = 2;

   logic             clk = 1'b0;
   logic             n_reset = 1'b0;
   logic             req_valid = 1'b0;
   logic             abort = 1'b0;
   logic [HP_W-1:0]  req_half_period = '0;
   logic [DUR_W-1:0] req_duration = '0;
   logic             req_ready;
   logic             buzz_out;
   logic             busy;

   always #5 clk = ~clk;

   beep_driver #(
      .HP_W       (HP_W),
      .DUR_W      (DUR_W),
      .TICK_CYCLES(TC),
      .GAP_TICKS  (GT)
   ) dut (
      .clk            (clk),
      .n_reset        (n_reset),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_half_period(req_half_period),
      .req_duration   (req_duration),
      .abort          (abort),
      .buzz_out       (buzz_out),
      .busy           (busy)
   );

   typedef struct packed {
      logic buzz;
      logic busy;
      logic ready;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   passed = 0;
   int   dut_accepts = 0;

   // Reference model: a beep occupies (D+GT)*TC edges after acceptance; during the first
   // D*TC of them the output has toggled floor(k/H) times.
   int m_rem = 0;
   int m_k = 0;
   int m_h = 0;
   int m_d = 0;
   int m_accepts = 0;

   task automatic check(input string name, input logic act, input logic req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, req);
   endtask

   task automatic model_edge();
      if (!n_reset) begin
         m_rem = 0;
         m_k   = 0;
      end else if (m_rem > 0) begin
         if (abort) begin
            m_rem = 0;
         end else begin
            m_rem--;
            m_k++;
         end
      end else if (req_valid && !abort) begin
         m_accepts++;
         if (req_duration != '0) begin
            m_h   = int'(req_half_period);
            m_d   = int'(req_duration);
            m_k   = 0;
            m_rem = (m_d + GT) * TC;
         end
      end
   endtask

   function automatic exp_t expect_now();
      exp_t e;
      e.busy  = (m_rem > 0);
      e.ready = (m_rem == 0) && !abort;
      e.buzz  = (m_rem > 0 && m_h != 0 && m_k < m_d * TC) ? (((m_k / m_h) % 2) == 1) : 1'b0;
      return e;
   endfunction

   task automatic cyc(input logic v, input int h, input int d, input logic ab);
      @(posedge clk);
      #1;
      model_edge();
      req_valid       = v;
      req_half_period = HP_W'(h);
      req_duration    = DUR_W'(d);
      abort           = ab;
      exp_q.push_back(expect_now());
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 0, 0, 1'b0);
   endtask

   always @(posedge clk) begin
      if (n_reset && req_valid && req_ready) dut_accepts++;
   end

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         check("buzz_out", buzz_out, mon_e.buzz);
         check("busy", busy, mon_e.busy);
         check("req_ready", req_ready, mon_e.ready);
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running, expected done");
      $fatal(1, "timeout");
   end

   initial begin
      int base;
      // Reset held with a request pending: nothing may be accepted.
      req_valid       = 1'b1;
      req_half_period = 16'd3;
      req_duration    = 8'd2;
      repeat (3) cyc(1'b1, 3, 2, 1'b0);
      n_reset = 1'b1;
      // First edge after release accepts H=3, D=2.
      cyc(1'b0, 0, 0, 1'b0);
      idle(45);

      // Silent rest.
      cyc(1'b1, 0, 1, 1'b0);
      idle(35);

      // Zero-duration requests are consumed back to back.
      repeat (4) cyc(1'b1, 5, 0, 1'b0);
      idle(3);

      // Abort 7 cycles into a tone with a request held behind it.
      cyc(1'b1, 3, 2, 1'b0);
      idle(6);
      cyc(1'b1, 2, 1, 1'b1);
      cyc(1'b1, 2, 1, 1'b0);
      idle(32);

      // Back-to-back H=1 beeps with valid held.
      base = m_accepts;
      cyc(1'b1, 1, 1, 1'b0);
      for (int i = 0; i < 80 && m_accepts < base + 2; i++) cyc(1'b1, 1, 1, 1'b0);
      idle(35);

      // Asynchronous reset pulse in the gap, then a normal accept.
      cyc(1'b1, 2, 1, 1'b0);
      idle(14);
      @(posedge clk);
      #1;
      model_edge();
      req_valid       = 1'b1;
      req_half_period = 16'd3;
      req_duration    = 8'd1;
      abort           = 1'b0;
      n_reset         = 1'b0;
      m_rem           = 0;
      m_k             = 0;
      exp_q.push_back(expect_now());
      #6 n_reset = 1'b1;
      cyc(1'b0, 0, 0, 1'b0);
      idle(32);

      // Randomized traffic including aborts.
      for (int i = 0; i < 400; i++) begin
         cyc($urandom_range(0, 2) == 0, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
             $urandom_range(0, 30) == 0);
      end
      idle(3);
      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
      #1;

      checks++;
      if (exp_q.size() == 0) passed++;
      else $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
      checks++;
      if (dut_accepts == m_accepts) passed++;
      else $display("FAIL accept_count: got %0d, expected %0d", dut_accepts, m_accepts);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/beep_driver.md
# beep_driver

Audible-feedback output driver for the game board: accepts beep requests (tone half-period, duration) over a valid/ready handshake and produces a square wave on the buzzer pin, followed by a fixed silent gap so consecutive beeps stay distinct. It is the output-side counterpart of the button debouncer. The debouncer conditions a noisy physical input; this block drives a clean, timed physical output. Game logic issues requests; `buzz_out` goes straight to the pad.

## Interface
- `HP_W`, 16, width of the half-period field, in clock cycles.
- `DUR_W`, 8, width of the duration field, in ticks.
- `TICK_CYCLES`, 38000, clock cycles per tick (1 ms at 38 MHz); must be at least 1.
- `GAP_TICKS`, 20, silent ticks after every tone; 0 means no gap.
- `clk` in 1: system clock; all state updates on the rising edge.
- `n_reset` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: a request is presented.
- `req_ready` out 1: the block can accept a request.
- `req_half_period` in HP_W: tone half-period in cycles; 0 means a silent rest.
- `req_duration` in DUR_W: tone length in ticks; 0 means discard the request.
- `abort` in 1: stop the current tone or gap immediately.
- `buzz_out` out 1: registered buzzer drive.
- `busy` out 1: high when the block is not idle.

## Operation
- The FSM has three states: IDLE, TONE, GAP.
- `req_ready` = (state==IDLE) & ~abort. It is combinational.
- `busy` = (state!=IDLE).
- Transfer rule: a request is accepted on a rising edge where `req_valid` & `req_ready` are both high.
- On accept with `req_duration`==0:
  - The request is consumed and discarded.
  - The block stays in IDLE, so back-to-back transfers every cycle are legal.
- On accept with `req_duration`!=0:
  - H and D are latched, and the FSM enters TONE.
  - The half-period counter, prescaler and tick counter are all cleared.
  - `buzz_out` is 0.
- TONE, half-period counter:
  - It increments every cycle.
  - When it equals H-1, `buzz_out` toggles and the counter clears.
  - H==0: no toggling; `buzz_out` stays 0.
- TONE, tick counting:
  - The prescaler counts 0..TICK_CYCLES-1 and pulses once per wrap.
  - The tick counter increments on each pulse.
  - When the D-th tick occurs: `buzz_out`←0 and the FSM enters GAP, or IDLE if GAP_TICKS==0.
- GAP:
  - The prescaler restarts from 0 and `buzz_out` holds 0.
  - After GAP_TICKS ticks the FSM enters IDLE.
- `abort` high in TONE or GAP:
  - On the next edge the FSM enters IDLE and `buzz_out` goes to 0.
  - All counters clear.
- `abort` in IDLE: it blocks acceptance that cycle and has no other effect.
- Simultaneous events:
  - Abort beats end-of-tone and toggle.
  - End-of-tone beats a coincident toggle, so `buzz_out` is 0.
- Arithmetic:
  - All counters are unsigned and never wrap past their terminal value.
  - The prescaler width is clog2(TICK_CYCLES), minimum 1.
  - The tick counter width is max(DUR_W, clog2(GAP_TICKS+1)).
- Reset, including mid-operation:
  - The FSM goes to IDLE immediately and all counters clear.
  - Outputs during and after reset: `buzz_out`=0, `busy`=0, `req_ready`=~abort.
  - No transfer occurs while `n_reset` is low.
  - A request held across reset release is accepted on the first rising edge after release.

## Timing
- Let accept edge be E0 and T=TICK_CYCLES.
- Tone phase:
  - `busy` goes high after E0.
  - `buzz_out` toggles after edges E0+kH for k≥1, while E0+kH < E0+D·T.
  - At edge E0+D·T the FSM leaves TONE and `buzz_out` is 0.
- Gap phase:
  - It ends at edge E0+(D+GAP_TICKS)·T.
  - `req_ready` is high in the following cycle, and the next accept can occur on the very next edge.
- Abort latency is 1 edge, and `req_ready` is high in the cycle after the abort edge.
- Total occupancy is exactly (D+GAP_TICKS)·T cycles, with no extra idle cycles between beeps.

## Structure
- Package `beep_pkg` holds:
  - the state typedef (IDLE, TONE, GAP);
  - default values for HP_W, DUR_W, TICK_CYCLES and GAP_TICKS.
- Sub-module `tick_prescaler`:
  - parameter TICK_CYCLES;
  - inputs `clk`, `n_reset`, `restart`;
  - output `tick`, a 1-cycle pulse on each wrap.
  - `restart` clears the count on the same edge.
- The FSM, the half-period counter and the tick counter live in `beep_driver`.

## Test plan
All scenarios use TICK_CYCLES=10 and GAP_TICKS=2.
- Reset: hold `n_reset` low with `abort`=0 → `buzz_out`=0, `busy`=0, `req_ready`=1; no transfer even with `req_valid`=1.
- Tone: H=3, D=2 accepted at E0 → `buzz_out` toggles after E0+3, 6, 9, 12, 15, 18; 0 from E0+20; `busy` through E0+40; `req_ready` high after E0+40.
- Rest and discard:
  - H=0, D=1 → `buzz_out` stays 0 while `busy` is high for 30 cycles.
  - D=0 presented on 4 consecutive cycles → 4 accepts, `busy` stays 0.
- Abort: abort raised 7 cycles into the H=3, D=2 tone → `buzz_out`=0, `busy`=0 after the next edge; a held request is accepted on the following edge.
- Back-to-back: `req_valid` held high with two H=1, D=1 requests → second accepted exactly at edge E0+30; H=1 produces toggling every cycle during the tone.
- Async reset mid-GAP: `n_reset` pulsed low between edges → `busy`, `buzz_out` drop without a clock edge; normal accept after release.
